// File: rtl/pulse_stretcher_pkg.sv
// Shared types, default parameters and the zero-to-one width mapping for pulse_stretcher.
package pulse_stretcher_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    HOLD = 2'b01,
    GAP  = 2'b10
  } state_e;

  localparam int DEF_WIDTH_W = 8;
  localparam int DEF_GAP     = 1;
  localparam int DEF_PEND_W  = 3;

  // A programmed width of zero still yields a one-cycle window.
  function automatic logic [31:0] eff_width(input logic [31:0] cfg);
    return (cfg == 32'd0) ? 32'd1 : cfg;
  endfunction

endpackage

// File: rtl/pulse_stretcher_cnt.sv
// Loadable down-counter; expire flags the last counted cycle (count==1, no load pending).
module pulse_stretcher_cnt #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] value,
  output logic         expire
);

  logic [W-1:0] cnt_r;

  // Count register: load wins, otherwise decrement down to zero and stop.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_r <= '0;
    end else if (load) begin
      cnt_r <= load_val;
    end else if (cnt_r != '0) begin
      cnt_r <= cnt_r - W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign value  = cnt_r;
  assign expire = (cnt_r == W'(1)) && !load;

endmodule

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle PULSE_IN events into LVL_OUT windows, queueing events that arrive mid-window.
// Optional macro PULSE_STRETCHER_RETRIGGER_EN: HOLD-time pulses extend the current window instead of queueing.
module pulse_stretcher
  import pulse_stretcher_pkg::*;
#(
  parameter int WIDTH_W = DEF_WIDTH_W,
  parameter int GAP     = DEF_GAP,
  parameter int PEND_W  = DEF_PEND_W
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               PULSE_IN,
  input  logic [WIDTH_W-1:0] WIDTH_CFG,
  input  logic               OVR_CLR,
  output logic               LVL_OUT,
  output logic               BUSY,
  output logic [PEND_W-1:0]  PEND_CNT,
  output logic               OVERRUN
);

  localparam int GAP_CW = $clog2(GAP + 1);

  state_e              state_r, state_s;
  logic                hold_load_s, gap_load_s;
  logic                hold_exp_s, gap_exp_s;
  logic [WIDTH_W-1:0]  hold_val_s, new_w_s;
  logic [WIDTH_W-1:0]  hold_cnt_s;
  logic [GAP_CW-1:0]   gap_cnt_s;
  logic                enq_s, deq_s, ovf_s;
  logic [PEND_W-1:0]   pend_r, pend_s;
  logic                ovr_r, ovr_s;
  logic                lvl_r, busy_r;
  logic                unused_s;

  assign new_w_s  = WIDTH_W'(eff_width(32'(WIDTH_CFG)));
  assign unused_s = ^{hold_cnt_s, gap_cnt_s};

`ifdef PULSE_STRETCHER_RETRIGGER_EN
  logic               retrig_s;
  logic [WIDTH_W-1:0] w_r;

  // Width of the window in progress, reused when a HOLD-time pulse retriggers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      w_r <= '0;
    end else if (hold_load_s && !retrig_s) begin
      w_r <= new_w_s;
    end else begin
      w_r <= w_r;
    end
  end

  assign hold_val_s = retrig_s ? w_r : new_w_s;
`else
  assign hold_val_s = new_w_s;
`endif

  pulse_stretcher_cnt #(.W(WIDTH_W)) u_hold_cnt (
    .CLK      (CLK),
    .RST      (RST),
    .load     (hold_load_s),
    .load_val (hold_val_s),
    .value    (hold_cnt_s),
    .expire   (hold_exp_s)
  );

  pulse_stretcher_cnt #(.W(GAP_CW)) u_gap_cnt (
    .CLK      (CLK),
    .RST      (RST),
    .load     (gap_load_s),
    .load_val (GAP_CW'(GAP)),
    .value    (gap_cnt_s),
    .expire   (gap_exp_s)
  );

  // Next-state, counter loads and queue push/pop decisions.
  always_comb begin
    state_s     = state_r;
    hold_load_s = 1'b0;
    gap_load_s  = 1'b0;
    enq_s       = 1'b0;
    deq_s       = 1'b0;
`ifdef PULSE_STRETCHER_RETRIGGER_EN
    retrig_s    = 1'b0;
`endif
    case (state_r)
      IDLE: begin
        // A queued event is served before a same-cycle pulse, which then queues.
        if (pend_r != '0) begin
          state_s     = HOLD;
          hold_load_s = 1'b1;
          deq_s       = 1'b1;
          enq_s       = PULSE_IN;
        end else if (PULSE_IN) begin
          state_s     = HOLD;
          hold_load_s = 1'b1;
        end else begin
          state_s     = IDLE;
        end
      end
      HOLD: begin
`ifdef PULSE_STRETCHER_RETRIGGER_EN
        if (PULSE_IN) begin
          hold_load_s = 1'b1;
          retrig_s    = 1'b1;
        end else if (hold_exp_s) begin
          state_s    = pulse_stretcher_pkg::GAP;
          gap_load_s = 1'b1;
        end else begin
          state_s    = HOLD;
        end
`else
        enq_s = PULSE_IN;
        if (hold_exp_s) begin
          state_s    = pulse_stretcher_pkg::GAP;
          gap_load_s = 1'b1;
        end else begin
          state_s    = HOLD;
        end
`endif
      end
      pulse_stretcher_pkg::GAP: begin
        if (gap_exp_s) begin
          if (pend_r != '0) begin
            state_s     = HOLD;
            hold_load_s = 1'b1;
            deq_s       = 1'b1;
            enq_s       = PULSE_IN;
          end else if (PULSE_IN) begin
            state_s     = HOLD;
            hold_load_s = 1'b1;
          end else begin
            state_s     = IDLE;
          end
        end else begin
          enq_s = PULSE_IN;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Saturating pending counter and sticky overrun; overflow beats a same-edge clear.
  always_comb begin
    pend_s = pend_r;
    ovf_s  = 1'b0;
    if (enq_s && !deq_s) begin
      if (pend_r == {PEND_W{1'b1}}) begin
        ovf_s = 1'b1;
      end else begin
        pend_s = pend_r + PEND_W'(1);
      end
    end else if (deq_s && !enq_s) begin
      pend_s = pend_r - PEND_W'(1);
    end else begin
      pend_s = pend_r;
    end
    if (ovf_s) begin
      ovr_s = 1'b1;
    end else if (OVR_CLR) begin
      ovr_s = 1'b0;
    end else begin
      ovr_s = ovr_r;
    end
  end

  // State, queue and registered outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= IDLE;
      pend_r  <= '0;
      ovr_r   <= 1'b0;
      lvl_r   <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      pend_r  <= pend_s;
      ovr_r   <= ovr_s;
      lvl_r   <= (state_s == HOLD);
      busy_r  <= (state_s != IDLE) || (pend_s != '0);
    end
  end

  assign LVL_OUT  = lvl_r;
  assign BUSY     = busy_r;
  assign PEND_CNT = pend_r;
  assign OVERRUN  = ovr_r;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed self-checking bench for pulse_stretcher (default build, PEND_W=2).
module tb_pulse_stretcher;

  logic       CLK = 1'b0;
  logic       RST;
  logic       PULSE_IN;
  logic [7:0] WIDTH_CFG;
  logic       OVR_CLR;
  logic       LVL_OUT;
  logic       BUSY;
  logic [1:0] PEND_CNT;
  logic       OVERRUN;

  int checks = 0;
  int errors = 0;

  int lvl3  [10] = '{1, 1, 0, 1, 1, 0, 1, 1, 0, 0};
  int pend3 [10] = '{0, 1, 2, 1, 1, 1, 0, 0, 0, 0};
  int pul3  [10] = '{1, 1, 1, 0, 0, 0, 0, 0, 0, 0};

  pulse_stretcher #(.WIDTH_W(8), .GAP(1), .PEND_W(2)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .PULSE_IN  (PULSE_IN),
    .WIDTH_CFG (WIDTH_CFG),
    .OVR_CLR   (OVR_CLR),
    .LVL_OUT   (LVL_OUT),
    .BUSY      (BUSY),
    .PEND_CNT  (PEND_CNT),
    .OVERRUN   (OVERRUN)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive PULSE_IN for one cycle; outputs then reflect the edge that sampled it.
  task automatic cyc(input logic p);
    PULSE_IN = p;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int win;
    logic prev;
    RST = 1'b1; PULSE_IN = 1'b0; WIDTH_CFG = 8'd4; OVR_CLR = 1'b0;
    #12;
    chk("rst_lvl", LVL_OUT, 1'b0);
    chk("rst_busy", BUSY, 1'b0);
    chk("rst_pend", PEND_CNT, 2'd0);
    chk("rst_ovr", OVERRUN, 1'b0);
    RST = 1'b0;

    // Single pulse, width 4; a mid-window WIDTH_CFG change must not matter.
    cyc(1'b1);
    WIDTH_CFG = 8'd7;
    chk("w4_hi0", LVL_OUT, 1'b1);
    chk("w4_busy", BUSY, 1'b1);
    for (int i = 1; i < 4; i++) begin
      cyc(1'b0);
      chk($sformatf("w4_hi%0d", i), LVL_OUT, 1'b1);
    end
    cyc(1'b0);
    chk("w4_gap_lo", LVL_OUT, 1'b0);
    chk("w4_gap_busy", BUSY, 1'b1);
    cyc(1'b0);
    chk("w4_idle_busy", BUSY, 1'b0);
    chk("w4_idle_lvl", LVL_OUT, 1'b0);

    // Zero width maps to a single-cycle window.
    WIDTH_CFG = 8'd0;
    cyc(1'b1);
    chk("w0_hi", LVL_OUT, 1'b1);
    cyc(1'b0);
    chk("w0_lo", LVL_OUT, 1'b0);
    cyc(1'b0);
    chk("w0_idle", BUSY, 1'b0);

    // Burst of three pulses, width 2: three 2-cycle windows split by 1 low cycle.
    WIDTH_CFG = 8'd2;
    for (int i = 0; i < 10; i++) begin
      cyc(pul3[i][0]);
      chk($sformatf("burst_lvl%0d", i), LVL_OUT, lvl3[i]);
      chk($sformatf("burst_pend%0d", i), PEND_CNT, pend3[i]);
    end
    chk("burst_idle", BUSY, 1'b0);

    // Six pulses into a long window: 3 queued, 2 dropped, overflow beats same-edge clear.
    WIDTH_CFG = 8'd20;
    for (int i = 0; i < 5; i++) cyc(1'b1);
    chk("ovf_pend", PEND_CNT, 2'd3);
    chk("ovf_flag", OVERRUN, 1'b1);
    OVR_CLR = 1'b1;
    cyc(1'b1);
    chk("ovf_wins_clr", OVERRUN, 1'b1);
    chk("ovf_pend_hold", PEND_CNT, 2'd3);
    cyc(1'b0);
    OVR_CLR = 1'b0;
    chk("ovr_cleared", OVERRUN, 1'b0);
    win = 1;
    prev = LVL_OUT;
    for (int i = 0; i < 300 && BUSY; i++) begin
      cyc(1'b0);
      if (LVL_OUT && !prev) win++;
      prev = LVL_OUT;
    end
    chk("ovf_drained", BUSY, 1'b0);
    chk("ovf_windows", win, 4);

    // Async reset mid-HOLD with two queued events discards everything.
    WIDTH_CFG = 8'd10;
    cyc(1'b1); cyc(1'b1); cyc(1'b1);
    PULSE_IN = 1'b0;
    chk("pre_rst_pend", PEND_CNT, 2'd2);
    chk("pre_rst_lvl", LVL_OUT, 1'b1);
    #2 RST = 1'b1;
    #1;
    chk("arst_lvl", LVL_OUT, 1'b0);
    chk("arst_busy", BUSY, 1'b0);
    chk("arst_pend", PEND_CNT, 2'd0);
    chk("arst_ovr", OVERRUN, 1'b0);
    @(posedge CLK);
    #3 RST = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0);
      chk($sformatf("post_rst_lvl%0d", i), LVL_OUT, 1'b0);
      chk($sformatf("post_rst_busy%0d", i), BUSY, 1'b0);
    end
    cyc(1'b1);
    chk("post_rst_new", LVL_OUT, 1'b1);
    cyc(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
